lif_neuron_spike_gen: RTL and testbench
=======================================

Name: lif_neuron_spike_gen

Overview:
- Upstream stage of the spike-out Wishbone slave, which holds 64 neuron spike bits as four 16-bit words.
- Integrates per-neuron synaptic sums from the crossbar accumulator into 64 leaky integrate-and-fire (LIF) membrane potentials, one timestep at a time.
- Packs fired spikes into 16-bit words and writes each word to the spike-out block through its own Wishbone master port.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone byte address of spike-out word 0.
- LEAK_SHIFT, 4, leak = v >>> LEAK_SHIFT (arithmetic), range 1..15.
- V_RESET, 16'sd0, membrane value loaded after a spike.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous active-high reset
- start_i  in  1  begin a timestep; accepted only in IDLE
- clear_i  in  1  zero all 64 potentials; accepted only in IDLE
- threshold_i  in  16  signed firing threshold, sampled per handshake
- in_valid_i  in  1  synaptic sum valid
- in_data_i  in  16  signed synaptic sum for the current neuron
- in_ready_o  out  1  block accepts in_data_i
- m_cyc_o  out  1  Wishbone master cycle
- m_stb_o  out  1  Wishbone master strobe
- m_we_o  out  1  Wishbone master write enable, always 1 when strobing
- m_sel_o  out  4  byte selects
- m_adr_o  out  32  write address
- m_dat_o  out  32  write data
- m_ack_i  in  1  slave acknowledge
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse at end of timestep

Behaviour:
- Reset (async): state IDLE; all outputs 0; all 64 potentials 0; neuron index 0; spike word 0.
- Storage: 64 x 16-bit signed registers, 6-bit neuron index idx, 16-bit spike shift word.
- IDLE:
  - clear_i=1 zeroes all potentials in one cycle.
  - Otherwise start_i=1 resets idx to 0 and the spike word to 0, then enters INTEG.
  - If clear_i and start_i are both high, clear wins and start is ignored.
- INTEG:
  - in_ready_o=1. Handshake = in_valid_i & in_ready_o.
  - Per handshake for neuron idx: s = v - (v >>> LEAK_SHIFT) + in_data_i, computed in 18-bit signed, saturated to [-32768, 32767].
  - If s >= threshold_i (signed): spike bit[idx[3:0]] = 1 and v <= V_RESET. Otherwise v <= s.
  - idx increments on every handshake. When the handshake hits idx[3:0]==15, go to WRITE with the completed word.
- WRITE:
  - in_ready_o=0; m_cyc_o=m_stb_o=m_we_o=1; m_sel_o=4'b0011.
  - m_adr_o = BASE_ADDR + {group, 1'b0}, where group = idx[5:4] of the word just packed (byte addresses +0, +2, +4, +6).
  - m_dat_o = {16'h0, spike_word}.
  - Hold all master outputs stable until m_ack_i=1 is sampled. cyc/stb then drop at the next edge.
  - Next state: DONE if group==3, else INTEG with the spike word cleared.
  - m_ack_i is ignored outside WRITE. A lingering ack is tolerated: at least 16 cycles separate writes.
- DONE: done_o=1 for one cycle, then IDLE.
- Latency: minimum 64 handshake cycles + 4 x (1 + ack wait) write cycles + 1 DONE cycle. With a one-cycle-ack slave that is 64 + 8 + 1 = 73 cycles from the start accept to done_o.
- start_i and clear_i outside IDLE are ignored. in_valid_i outside INTEG is ignored.
- Reset mid-WRITE drops m_cyc_o and m_stb_o immediately (async) and discards the partial timestep.

Optional Feature:
- Macro: LIF_SPIKE_COUNT_EN.
- Defined:
  - Adds output spike_count_o (7 bits, 0..64).
  - Cleared on start accept; +1 per spike.
  - Value is final and stable from the done_o cycle until the next start accept.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert wb_rst_i mid-INTEG -> all outputs 0 asynchronously, busy_o=0; a following timestep with all inputs 0 gives potentials 0.
- Quiet timestep: clear, threshold 100, 64 inputs of 0 -> four writes to BASE+0/2/4/6, sel 4'b0011, dat 32'h0; done_o pulses once.
- Firing and reset: threshold 100; neurons 0 and 5 get 200, others 0 -> write 0 dat 32'h0000_0021. Next timestep, all inputs 0 -> no spikes (potentials at V_RESET).
- Leak: threshold 100; neuron 17 gets 50 (no spike, v=50). Next timestep it gets 60: 50 - 3 + 60 = 107 -> write at BASE+2, dat 32'h0000_0002.
- Saturation: threshold 100; neuron 63 gets -32768 for two timesteps -> v stays -32768, no spike, no wrap. Then one timestep with input +32767: -32768 + 2048 + 32767 = 2047 >= 100 -> spike in the BASE+6 word, dat bit 15 set.
- Ack stall: hold m_ack_i low 10 cycles in WRITE -> adr/dat/stb stable, in_ready_o=0. Ack then -> stb drops next cycle and INTEG resumes. With LIF_SPIKE_COUNT_EN, spike_count_o equals the number of spikes in the timestep at done_o.

Source files
------------

// File: rtl/lif_neuron_spike_gen.sv
// -----------------------------------------------------------------------------
// lif_neuron_spike_gen
//
// Purpose:
//   Integrates per-neuron synaptic sums into 64 leaky integrate-and-fire
//   membrane potentials, one timestep at a time. Neurons are processed in
//   index order 0..63. Each group of 16 neurons produces one 16-bit spike
//   word, which is written to the spike-out Wishbone slave through the
//   Wishbone master port. The words go to byte addresses BASE_ADDR + 0/2/4/6.
//
// Ports:
//   wb_clk_i, wb_rst_i   clock, asynchronous active-high reset
//   start_i              begin a timestep (accepted only when idle)
//   clear_i              zero all potentials (accepted only when idle, wins
//                        over start_i)
//   threshold_i          signed firing threshold, used on every handshake
//   in_valid_i/in_data_i signed synaptic sum stream for the current neuron
//   in_ready_o           high while integrating
//   m_*                  Wishbone master write port (one word per transfer)
//   busy_o               high whenever a timestep is in progress
//   done_o               one-cycle pulse at the end of a timestep
//   spike_count_o        (only with LIF_SPIKE_COUNT_EN) spikes in the
//                        current/last timestep, 0..64
//
// Build option:
//   `define LIF_SPIKE_COUNT_EN adds the spike counter and the spike_count_o
//   port. Without it the block has no counter and no such port.
// -----------------------------------------------------------------------------
module lif_neuron_spike_gen #(
    parameter logic [31:0]        BASE_ADDR  = 32'h3000_0000,
    parameter int                 LEAK_SHIFT = 4,
    parameter logic signed [15:0] V_RESET    = 16'sd0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic        clear_i,
    input  logic [15:0] threshold_i,
    input  logic        in_valid_i,
    input  logic [15:0] in_data_i,
    output logic        in_ready_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic        m_ack_i,
    output logic        busy_o,
`ifdef LIF_SPIKE_COUNT_EN
    output logic [6:0]  spike_count_o,
`endif
    output logic        done_o
);

    localparam int NEURONS = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INTEG = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         idx_q, idx_d;
    logic [15:0]        spike_q, spike_d;
    logic signed [15:0] v_q [NEURONS];

    // Potential write controls, applied in the register process.
    logic               clr_all;
    logic               v_we;
    logic signed [15:0] v_wdata;

    // Saturate an 18-bit signed intermediate into the 16-bit signed range.
    function automatic logic signed [15:0] sat16(input logic signed [17:0] x);
        if (x > 18'sd32767) begin
            return 16'sh7FFF;
        end else if (x < -18'sd32768) begin
            return 16'sh8000;
        end else begin
            return x[15:0];
        end
    endfunction

    // -------------------------------------------------------------------------
    // Membrane update datapath for the neuron at idx_q
    // -------------------------------------------------------------------------
    logic signed [15:0] thr_s;
    logic signed [15:0] din_s;
    logic signed [15:0] v_cur;
    logic signed [15:0] leak_s;
    logic signed [17:0] sum_s;
    logic signed [15:0] sum_sat;
    logic               fire;
    logic               hs;
    logic [1:0]         grp;

    assign thr_s   = threshold_i;
    assign din_s   = in_data_i;
    assign v_cur   = v_q[idx_q];
    assign leak_s  = v_cur >>> LEAK_SHIFT;
    // Each term is sign-extended by hand so the whole sum stays in 18 bits
    // and cannot wrap before saturation.
    assign sum_s   = {{2{v_cur[15]}}, v_cur}
                   - {{2{leak_s[15]}}, leak_s}
                   + {{2{din_s[15]}}, din_s};
    assign sum_sat = sat16(sum_s);
    assign fire    = (sum_sat >= thr_s);
    assign hs      = in_valid_i && (state_q == S_INTEG);

    // idx_q has already advanced past the packed word, so the group being
    // written is the one before idx_q[5:4]. The 2-bit wrap maps 0 to 3 after
    // the last group.
    assign grp = idx_q[5:4] - 2'd1;

`ifdef LIF_SPIKE_COUNT_EN
    logic [6:0] cnt_q, cnt_d;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        spike_d = spike_q;
        clr_all = 1'b0;
        v_we    = 1'b0;
        v_wdata = sum_sat;
`ifdef LIF_SPIKE_COUNT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (clear_i) begin
                    clr_all = 1'b1;
                end else if (start_i) begin
                    idx_d   = 6'd0;
                    spike_d = 16'd0;
`ifdef LIF_SPIKE_COUNT_EN
                    cnt_d   = 7'd0;
`endif
                    state_d = S_INTEG;
                end
            end
            S_INTEG: begin
                if (hs) begin
                    v_we  = 1'b1;
                    idx_d = idx_q + 6'd1;
                    if (fire) begin
                        v_wdata = V_RESET;
                        spike_d = spike_q | (16'd1 << idx_q[3:0]);
`ifdef LIF_SPIKE_COUNT_EN
                        cnt_d   = cnt_q + 7'd1;
`endif
                    end
                    if (idx_q[3:0] == 4'd15) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (m_ack_i) begin
                    if (grp == 2'd3) begin
                        state_d = S_DONE;
                    end else begin
                        spike_d = 16'd0;
                        state_d = S_INTEG;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= 6'd0;
            spike_q <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            spike_q <= spike_d;
        end
    end

`ifdef LIF_SPIKE_COUNT_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q <= 7'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign spike_count_o = cnt_q;
`endif

    // -------------------------------------------------------------------------
    // Membrane potential storage
    // -------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NEURONS; i++) begin
                v_q[i] <= 16'sd0;
            end
        end else if (clr_all) begin
            for (int i = 0; i < NEURONS; i++) begin
                v_q[i] <= 16'sd0;
            end
        end else if (v_we) begin
            v_q[idx_q] <= v_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from registered state so they stay stable while a write
    // waits for its acknowledge. The async reset of state_q drops cyc/stb.
    // -------------------------------------------------------------------------
    logic wr_act;
    assign wr_act     = (state_q == S_WRITE);

    assign in_ready_o = (state_q == S_INTEG);
    assign m_cyc_o    = wr_act;
    assign m_stb_o    = wr_act;
    assign m_we_o     = wr_act;
    assign m_sel_o    = wr_act ? 4'b0011 : 4'b0000;
    assign m_adr_o    = wr_act ? (BASE_ADDR + {29'd0, grp, 1'b0}) : 32'd0;
    assign m_dat_o    = wr_act ? {16'h0000, spike_q} : 32'd0;
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_lif_neuron_spike_gen.sv
`timescale 1ns/1ps
module tb_lif_neuron_spike_gen;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          LEAK = 4;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        start_i, clear_i;
    logic [15:0] threshold_i;
    logic        in_valid_i;
    logic [15:0] in_data_i;
    logic        in_ready_o;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_adr_o, m_dat_o;
    logic        m_ack_i;
    logic        busy_o, done_o;
`ifdef LIF_SPIKE_COUNT_EN
    logic [6:0]  spike_count_o;
`endif

    lif_neuron_spike_gen dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .start_i     (start_i),
        .clear_i     (clear_i),
        .threshold_i (threshold_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .m_cyc_o     (m_cyc_o),
        .m_stb_o     (m_stb_o),
        .m_we_o      (m_we_o),
        .m_sel_o     (m_sel_o),
        .m_adr_o     (m_adr_o),
        .m_dat_o     (m_dat_o),
        .m_ack_i     (m_ack_i),
        .busy_o      (busy_o),
`ifdef LIF_SPIKE_COUNT_EN
        .spike_count_o (spike_count_o),
`endif
        .done_o      (done_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks   = 0;
    int failures = 0;

    // ------------------------------------------------------------------
    // Wishbone slave: acks after stall_n low cycles, logs each write and
    // counts protocol problems (outputs changing while stalled, in_ready_o
    // high during a write, stb still high the cycle after ack).
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } wr_t;

    wr_t         wq[$];
    int          stall_n  = 0;
    int          wait_cnt = 0;
    bit          in_wr    = 0;
    int          unstable = 0;
    int          rdy_bad  = 0;
    logic [31:0] cap_adr, cap_dat;

    always @(negedge wb_clk_i) begin
        if (wb_rst_i) begin
            m_ack_i = 1'b0;
            in_wr   = 0;
        end else if (m_ack_i) begin
            m_ack_i = 1'b0;
            if (m_stb_o || m_cyc_o) unstable++;
        end else if (m_cyc_o && m_stb_o) begin
            if (!in_wr) begin
                in_wr    = 1;
                wait_cnt = 0;
                cap_adr  = m_adr_o;
                cap_dat  = m_dat_o;
            end else if (m_adr_o !== cap_adr || m_dat_o !== cap_dat) begin
                unstable++;
            end
            if (in_ready_o) rdy_bad++;
            if (wait_cnt >= stall_n) begin
                m_ack_i = 1'b1;
                in_wr   = 0;
                wq.push_back('{adr: m_adr_o, dat: m_dat_o, sel: m_sel_o, we: m_we_o});
            end else begin
                wait_cnt++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: potentials as plain integers
    // ------------------------------------------------------------------
    logic signed [15:0] stim [64];
    int                 pot  [64];
    logic [15:0]        exp_w [4];
    int                 exp_cnt;

    function automatic void model_clear();
        for (int n = 0; n < 64; n++) pot[n] = 0;
    endfunction

    function automatic void model_step(input logic signed [15:0] thr);
        int s;
        exp_cnt = 0;
        for (int g = 0; g < 4; g++) exp_w[g] = 16'h0;
        for (int n = 0; n < 64; n++) begin
            s = pot[n] - (pot[n] >>> LEAK) + int'(stim[n]);
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
            if (s >= int'(thr)) begin
                exp_w[n / 16][n % 16] = 1'b1;
                exp_cnt++;
                pot[n] = 0;
            end else begin
                pot[n] = s;
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // Timestep driver: starts, streams stim[], waits for done_o.
    // ------------------------------------------------------------------
    int   lat;
    logic done_after, busy_after;
    logic [6:0] cnt_at_done;

    task automatic run_timestep(input logic [15:0] thr);
        int  k;
        bit  hs;
        wq.delete();
        unstable    = 0;
        rdy_bad     = 0;
        lat         = 0;
        cnt_at_done = 7'd0;
        @(negedge wb_clk_i);
        threshold_i = thr;
        start_i     = 1'b1;
        @(posedge wb_clk_i);
        k = 0;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge wb_clk_i);
            start_i = 1'b0;
            if (done_o) begin
                lat = c;
`ifdef LIF_SPIKE_COUNT_EN
                cnt_at_done = spike_count_o;
`endif
                break;
            end
            in_valid_i = (k < 64);
            if (k < 64) in_data_i = stim[k];
            else        in_data_i = 16'h0;
            hs = in_ready_o && (k < 64);
            @(posedge wb_clk_i);
            if (hs) k++;
        end
        in_valid_i = 1'b0;
        in_data_i  = 16'h0;
        @(negedge wb_clk_i);
        done_after = done_o;
        busy_after = busy_o;
    endtask

    task automatic do_clear();
        @(negedge wb_clk_i);
        clear_i = 1'b1;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        clear_i = 1'b0;
        model_clear();
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        int  seen;
        wb_rst_i = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        checks++;
        if ({in_ready_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, busy_o, done_o} !== 10'd0
            || m_adr_o !== 32'd0 || m_dat_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b cyc=%b stb=%b we=%b sel=%b adr=%h dat=%h busy=%b done=%b exp all 0",
                     in_ready_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o, busy_o, done_o);
        end
        wb_rst_i = 1'b0;
        model_clear();

        // Reset during integration: accumulate positive values first.
        @(negedge wb_clk_i);
        threshold_i = 16'h7FFF;
        start_i     = 1'b1;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        start_i = 1'b0;
        repeat (20) begin
            in_valid_i = 1'b1;
            in_data_i  = 16'($urandom_range(50, 1000));
            @(negedge wb_clk_i);
        end
        #2 wb_rst_i = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0 || in_ready_o !== 1'b0 || m_cyc_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_integ got busy=%b rdy=%b cyc=%b done=%b exp 0", busy_o, in_ready_o, m_cyc_o, done_o);
        end
        in_valid_i = 1'b0;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        model_clear();

        // Reset during a stalled write.
        stall_n = 1000;
        @(negedge wb_clk_i);
        threshold_i = 16'd100;
        start_i     = 1'b1;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        start_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            in_valid_i = 1'b1;
            in_data_i  = 16'd0;
            if (m_stb_o) begin
                seen = 1;
                break;
            end
            @(negedge wb_clk_i);
        end
        in_valid_i = 1'b0;
        checks++;
        if (seen != 1) begin
            failures++;
            $display("FAIL reset_reach_write got no strobe within 60 cycles exp strobe");
        end
        repeat (2) @(negedge wb_clk_i);
        #2 wb_rst_i = 1'b1;
        #1;
        checks++;
        if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_write got cyc=%b stb=%b busy=%b exp 0", m_cyc_o, m_stb_o, busy_o);
        end
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        stall_n  = 0;
        model_clear();

        // A following timestep with all-zero inputs: a low threshold would
        // fire on any surviving positive potential.
        for (int n = 0; n < 64; n++) stim[n] = 16'sd0;
        model_step(16'sd1);
        run_timestep(16'd1);
        checks++;
        if (wq.size() != 4) begin
            failures++;
            $display("FAIL reset_after_nwrites got=%0d exp=4", wq.size());
        end else begin
            for (int g = 0; g < 4; g++) begin
                checks++;
                if (wq[g].dat !== {16'h0, exp_w[g]} || wq[g].adr !== BASE + 32'(2 * g)) begin
                    failures++;
                    $display("FAIL reset_after_w%0d got adr=%h dat=%h exp adr=%h dat=%h",
                             g, wq[g].adr, wq[g].dat, BASE + 32'(2 * g), {16'h0, exp_w[g]});
                end
            end
        end
    endtask

    task automatic test_quiet();
        do_clear();
        stall_n = 1;
        for (int n = 0; n < 64; n++) stim[n] = 16'sd0;
        model_step(16'sd100);
        run_timestep(16'd100);
        stall_n = 0;
        checks++;
        if (lat != 73) begin
            failures++;
            $display("FAIL quiet_latency got=%0d exp=73", lat);
        end
        checks++;
        if (done_after !== 1'b0 || busy_after !== 1'b0) begin
            failures++;
            $display("FAIL quiet_done_pulse got done_next=%b busy_next=%b exp 0 0", done_after, busy_after);
        end
        checks++;
        if (wq.size() != 4) begin
            failures++;
            $display("FAIL quiet_nwrites got=%0d exp=4", wq.size());
        end else begin
            for (int g = 0; g < 4; g++) begin
                checks++;
                if (wq[g].adr !== BASE + 32'(2 * g) || wq[g].dat !== {16'h0, exp_w[g]}
                    || wq[g].sel !== 4'b0011 || wq[g].we !== 1'b1) begin
                    failures++;
                    $display("FAIL quiet_w%0d got adr=%h dat=%h sel=%b we=%b exp adr=%h dat=%h sel=0011 we=1",
                             g, wq[g].adr, wq[g].dat, wq[g].sel, wq[g].we, BASE + 32'(2 * g), {16'h0, exp_w[g]});
                end
            end
        end
    endtask

    task automatic test_fire_reset();
        do_clear();
        for (int step = 0; step < 2; step++) begin
            for (int n = 0; n < 64; n++) stim[n] = 16'sd0;
            if (step == 0) begin
                stim[0] = 16'sd200;
                stim[5] = 16'sd200;
            end
            model_step(16'sd100);
            run_timestep(16'd100);
            checks++;
            if (wq.size() != 4) begin
                failures++;
                $display("FAIL fire_s%0d_nwrites got=%0d exp=4", step, wq.size());
            end else begin
                for (int g = 0; g < 4; g++) begin
                    checks++;
                    if (wq[g].adr !== BASE + 32'(2 * g) || wq[g].dat !== {16'h0, exp_w[g]}) begin
                        failures++;
                        $display("FAIL fire_s%0d_w%0d got adr=%h dat=%h exp adr=%h dat=%h",
                                 step, g, wq[g].adr, wq[g].dat, BASE + 32'(2 * g), {16'h0, exp_w[g]});
                    end
                end
            end
        end
    endtask

    task automatic test_leak();
        do_clear();
        for (int step = 0; step < 2; step++) begin
            for (int n = 0; n < 64; n++) stim[n] = 16'sd0;
            stim[17] = (step == 0) ? 16'sd50 : 16'sd60;
            model_step(16'sd100);
            run_timestep(16'd100);
            checks++;
            if (wq.size() != 4) begin
                failures++;
                $display("FAIL leak_s%0d_nwrites got=%0d exp=4", step, wq.size());
            end else begin
                checks++;
                if (wq[1].adr !== BASE + 32'd2 || wq[1].dat !== {16'h0, exp_w[1]}) begin
                    failures++;
                    $display("FAIL leak_s%0d_w1 got adr=%h dat=%h exp adr=%h dat=%h",
                             step, wq[1].adr, wq[1].dat, BASE + 32'd2, {16'h0, exp_w[1]});
                end
            end
        end
    endtask

    task automatic test_saturation();
        do_clear();
        for (int step = 0; step < 3; step++) begin
            for (int n = 0; n < 64; n++) stim[n] = 16'sd0;
            stim[63] = (step < 2) ? -16'sd32768 : 16'sd32767;
            model_step(16'sd100);
            run_timestep(16'd100);
            checks++;
            if (wq.size() != 4) begin
                failures++;
                $display("FAIL sat_s%0d_nwrites got=%0d exp=4", step, wq.size());
            end else begin
                checks++;
                if (wq[3].adr !== BASE + 32'd6 || wq[3].dat !== {16'h0, exp_w[3]}) begin
                    failures++;
                    $display("FAIL sat_s%0d_w3 got adr=%h dat=%h exp adr=%h dat=%h",
                             step, wq[3].adr, wq[3].dat, BASE + 32'd6, {16'h0, exp_w[3]});
                end
            end
        end
    endtask

    task automatic test_clear_start();
        logic [15:0] thr;
        do_clear();
        for (int n = 0; n < 64; n++) stim[n] = 16'($urandom_range(10, 500));
        thr = 16'h7FFF;
        model_step(thr);
        run_timestep(thr);
        // Both high together: clear must win and no timestep may start.
        @(negedge wb_clk_i);
        clear_i = 1'b1;
        start_i = 1'b1;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        clear_i = 1'b0;
        start_i = 1'b0;
        model_clear();
        checks++;
        if (busy_o !== 1'b0 || in_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL clear_start_busy got busy=%b rdy=%b exp 0 0", busy_o, in_ready_o);
        end
        for (int n = 0; n < 64; n++) stim[n] = 16'sd0;
        model_step(16'sd1);
        run_timestep(16'd1);
        checks++;
        if (wq.size() != 4 || wq[0].dat !== {16'h0, exp_w[0]} || wq[1].dat !== {16'h0, exp_w[1]}
            || wq[2].dat !== {16'h0, exp_w[2]} || wq[3].dat !== {16'h0, exp_w[3]}) begin
            failures++;
            $display("FAIL clear_start_words got n=%0d w0=%h exp n=4 all words %h %h %h %h",
                     wq.size(), (wq.size() > 0) ? wq[0].dat : 32'hx, exp_w[0], exp_w[1], exp_w[2], exp_w[3]);
        end
    endtask

    task automatic test_ack_stall();
        logic signed [15:0] thr;
        do_clear();
        for (int n = 0; n < 64; n++) stim[n] = 16'($urandom_range(0, 300));
        thr = 16'sd150;
        stall_n = 10;
        model_step(thr);
        run_timestep(thr);
        stall_n = 0;
        checks++;
        if (unstable != 0 || rdy_bad != 0) begin
            failures++;
            $display("FAIL stall_protocol got unstable=%0d ready_in_write=%0d exp 0 0", unstable, rdy_bad);
        end
        checks++;
        if (lat != 109) begin
            failures++;
            $display("FAIL stall_latency got=%0d exp=109", lat);
        end
        checks++;
        if (wq.size() != 4) begin
            failures++;
            $display("FAIL stall_nwrites got=%0d exp=4", wq.size());
        end else begin
            for (int g = 0; g < 4; g++) begin
                checks++;
                if (wq[g].adr !== BASE + 32'(2 * g) || wq[g].dat !== {16'h0, exp_w[g]}) begin
                    failures++;
                    $display("FAIL stall_w%0d got adr=%h dat=%h exp adr=%h dat=%h",
                             g, wq[g].adr, wq[g].dat, BASE + 32'(2 * g), {16'h0, exp_w[g]});
                end
            end
        end
`ifdef LIF_SPIKE_COUNT_EN
        checks++;
        if (cnt_at_done !== 7'(exp_cnt)) begin
            failures++;
            $display("FAIL stall_spike_count got=%0d exp=%0d", cnt_at_done, exp_cnt);
        end
`endif
    endtask

    task automatic test_random();
        logic signed [15:0] thr;
        do_clear();
        for (int step = 0; step < 5; step++) begin
            for (int n = 0; n < 64; n++) begin
                if ($urandom_range(0, 3) == 0) stim[n] = 16'($urandom);
                else                           stim[n] = 16'sd0 + 16'($urandom_range(0, 400)) - 16'sd200;
            end
            thr     = 16'sd0 + 16'($urandom_range(0, 600)) - 16'sd300;
            stall_n = int'($urandom_range(0, 3));
            model_step(thr);
            run_timestep(thr);
            checks++;
            if (wq.size() != 4 || lat == 0) begin
                failures++;
                $display("FAIL rand_s%0d_nwrites got=%0d lat=%0d exp=4 writes", step, wq.size(), lat);
            end else begin
                for (int g = 0; g < 4; g++) begin
                    checks++;
                    if (wq[g].adr !== BASE + 32'(2 * g) || wq[g].dat !== {16'h0, exp_w[g]}) begin
                        failures++;
                        $display("FAIL rand_s%0d_w%0d got adr=%h dat=%h exp adr=%h dat=%h",
                                 step, g, wq[g].adr, wq[g].dat, BASE + 32'(2 * g), {16'h0, exp_w[g]});
                    end
                end
            end
`ifdef LIF_SPIKE_COUNT_EN
            checks++;
            if (cnt_at_done !== 7'(exp_cnt)) begin
                failures++;
                $display("FAIL rand_s%0d_spike_count got=%0d exp=%0d", step, cnt_at_done, exp_cnt);
            end
`endif
        end
        stall_n = 0;
    endtask

    initial begin
        start_i     = 1'b0;
        clear_i     = 1'b0;
        threshold_i = 16'd0;
        in_valid_i  = 1'b0;
        in_data_i   = 16'd0;
        m_ack_i     = 1'b0;
        wb_rst_i    = 1'b1;
        test_reset();
        test_quiet();
        test_fire_reset();
        test_leak();
        test_saturation();
        test_clear_start();
        test_ack_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
